// File: rtl/bias_add_pkg.sv
// Shared width helpers and fixed-point primitives for the bias-add datapath.
// Lane vectors are declared in each user as logic [LANES-1:0][WIDTH-1:0].
package bias_add_pkg;

    // Wide signed carrier for the fixed-point helpers; callers size-cast the result.
    typedef logic signed [63:0] fx_wide_t;

    function automatic int int_bits(input int total, input int frac);
        return total - frac;
    endfunction

    // Wide enough that data + aligned bias can never overflow.
    function automatic int sum_width(input int din_p0, input int din_p1,
                                     input int b_p0, input int b_p1);
        int di;
        int bi;
        di = int_bits(din_p0, din_p1);
        bi = int_bits(b_p0, b_p1);
        return ((di > bi) ? di : bi) + din_p1 + 2;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Positive sh moves the point left (multiply); negative truncates toward -inf.
    function automatic fx_wide_t fx_align(input fx_wide_t v, input int sh);
        fx_wide_t r;
        if (sh >= 0) r = v <<< sh;
        else         r = v >>> (-sh);
        return r;
    endfunction

    function automatic fx_wide_t fx_saturate(input fx_wide_t v, input int n);
        fx_wide_t hi;
        fx_wide_t lo;
        fx_wide_t r;
        hi = (fx_wide_t'(1) <<< (n - 1)) - fx_wide_t'(1);
        lo = -(fx_wide_t'(1) <<< (n - 1));
        if (v > hi)      r = hi;
        else if (v < lo) r = lo;
        else             r = v;
        return r;
    endfunction

endpackage

// File: rtl/bias_add_pipe_reg.sv
// One elastic valid/ready register stage; accepts whenever empty or being drained.
module bias_add_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             accept_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ready_i
);

    logic             vld_q;
    logic [WIDTH-1:0] data_q;

    assign accept_o = !vld_q || ready_i;
    assign valid_o  = vld_q;
    assign data_o   = data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (accept_o) begin
            vld_q <= valid_i;
            // Payload only moves on a real beat so a stalled output stays stable.
            if (valid_i) data_q <= data_i;
        end
    end

endmodule

// File: rtl/encoder_bias_add.sv
// Joins matmul-result and bias streams, adds them lane-wise with format alignment,
// saturates to the output format and emits through two elastic stages with a row-end flag.
module encoder_bias_add
    import bias_add_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0  = 16,
    parameter int DATA_IN_0_PRECISION_1  = 3,
    parameter int BIAS_PRECISION_0       = 16,
    parameter int BIAS_PRECISION_1       = 3,
    parameter int DATA_OUT_0_PRECISION_0 = 16,
    parameter int DATA_OUT_0_PRECISION_1 = 3,
    parameter int TENSOR_SIZE_DIM_0      = 32,
    parameter int PARALLELISM_DIM_0      = 1,
    parameter int PARALLELISM_DIM_1      = 1,
    parameter int OUT_DEPTH              = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0
) (
    input  logic clk,
    input  logic rst,
    input  logic [PARALLELISM_DIM_0*PARALLELISM_DIM_1-1:0][DATA_IN_0_PRECISION_0-1:0]  data_in_0,
    input  logic data_in_0_valid,
    output logic data_in_0_ready,
    input  logic [PARALLELISM_DIM_0*PARALLELISM_DIM_1-1:0][BIAS_PRECISION_0-1:0]       bias,
    input  logic bias_valid,
    output logic bias_ready,
    output logic [PARALLELISM_DIM_0*PARALLELISM_DIM_1-1:0][DATA_OUT_0_PRECISION_0-1:0] data_out_0,
    output logic data_out_0_valid,
    input  logic data_out_0_ready,
    output logic data_out_0_last
);

    localparam int L       = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
    localparam int SUM_W   = sum_width(DATA_IN_0_PRECISION_0, DATA_IN_0_PRECISION_1,
                                       BIAS_PRECISION_0, BIAS_PRECISION_1);
    localparam int CNT_W   = cnt_width(OUT_DEPTH);
    localparam int BIAS_SH = DATA_IN_0_PRECISION_1 - BIAS_PRECISION_1;
    localparam int OUT_SH  = DATA_OUT_0_PRECISION_1 - DATA_IN_0_PRECISION_1;
    localparam int A_W     = L * SUM_W + 1;
    localparam int B_W     = L * DATA_OUT_0_PRECISION_0 + 1;

    typedef logic [L-1:0][SUM_W-1:0]                  sum_vec_t;
    typedef logic [L-1:0][DATA_OUT_0_PRECISION_0-1:0] out_vec_t;

    logic             a_accept;
    logic             b_accept;
    logic             fire;
    logic             fire_last;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    sum_vec_t         sum_d;
    sum_vec_t         a_sum;
    logic             a_valid;
    logic             a_last;
    logic [A_W-1:0]   a_data;

    out_vec_t         res_d;
    logic [B_W-1:0]   b_data;

    // Each side is only ready when the other is offering, so the streams never slip.
    assign data_in_0_ready = bias_valid && a_accept;
    assign bias_ready      = data_in_0_valid && a_accept;
    assign fire            = data_in_0_valid && bias_valid && a_accept;

    assign fire_last = (cnt_q == CNT_W'(OUT_DEPTH - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (fire) cnt_d = fire_last ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    for (genvar l = 0; l < L; l++) begin : g_lane
        assign sum_d[l] = SUM_W'(fx_wide_t'(signed'(data_in_0[l]))
                                 + fx_align(fx_wide_t'(signed'(bias[l])), BIAS_SH));
        assign res_d[l] = DATA_OUT_0_PRECISION_0'(
                              fx_saturate(fx_align(fx_wide_t'(signed'(a_sum[l])), OUT_SH),
                                          DATA_OUT_0_PRECISION_0));
    end

    bias_add_pipe_reg #(.WIDTH(A_W)) u_stage_a (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (fire),
        .data_i   ({fire_last, sum_d}),
        .accept_o (a_accept),
        .valid_o  (a_valid),
        .data_o   (a_data),
        .ready_i  (b_accept)
    );

    assign {a_last, a_sum} = a_data;

    bias_add_pipe_reg #(.WIDTH(B_W)) u_stage_b (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (a_valid),
        .data_i   ({a_last, res_d}),
        .accept_o (b_accept),
        .valid_o  (data_out_0_valid),
        .data_o   (b_data),
        .ready_i  (data_out_0_ready)
    );

    assign {data_out_0_last, data_out_0} = b_data;

endmodule

// File: tb/tb_encoder_bias_add.sv
// Bench for encoder_bias_add: directed vector table plus scoreboarded random streams,
// driving a Q16.3 instance and a bias-Q16.5 instance from the same inputs.
module tb_encoder_bias_add;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [0:0][15:0] din, bin, dout0, dout1;
    logic din_v, b_v, out_rdy;
    logic din_rdy0, b_rdy0, dout_v0, last0;
    logic din_rdy1, b_rdy1, dout_v1, last1;

    encoder_bias_add u_dut0 (
        .clk(clk), .rst(rst),
        .data_in_0(din), .data_in_0_valid(din_v), .data_in_0_ready(din_rdy0),
        .bias(bin), .bias_valid(b_v), .bias_ready(b_rdy0),
        .data_out_0(dout0), .data_out_0_valid(dout_v0), .data_out_0_ready(out_rdy),
        .data_out_0_last(last0)
    );

    encoder_bias_add #(.BIAS_PRECISION_1(5)) u_dut1 (
        .clk(clk), .rst(rst),
        .data_in_0(din), .data_in_0_valid(din_v), .data_in_0_ready(din_rdy1),
        .bias(bin), .bias_valid(b_v), .bias_ready(b_rdy1),
        .data_out_0(dout1), .data_out_0_valid(dout_v1), .data_out_0_ready(out_rdy),
        .data_out_0_last(last1)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: real-valued sum of data (frac 3) and bias (frac bf), floored to frac 3, clamped to 16 bits.
    function automatic int floor_div(input int a, input int m);
        int q;
        q = a / m;
        if ((a % m != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int model(input int d, input int b, input int bf);
        int s;
        if (bf >= 3) s = d + floor_div(b, 1 << (bf - 3));
        else         s = d + b * (1 << (3 - bf));
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    typedef struct { int data; bit last; } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int  col = 0;
    int  n_data_hs = 0, n_bias_hs = 0, n_out0 = 0, n_last0 = 0;
    bit  sb_en = 1'b0;
    bit  drv_rand = 1'b0;

    // Scoreboard: sampled mid-cycle, each handshake that will happen at the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && sb_en) begin
                if (dout_v0 && out_rdy) begin
                    if (q0.size() == 0) chk("sb0_unexpected_beat", 1, 0);
                    else begin
                        e0 = q0.pop_front();
                        chk("sb0_data", int'($signed(dout0[0])), e0.data);
                        chk("sb0_last", int'(last0), int'(e0.last));
                        n_out0++;
                        if (last0) n_last0++;
                    end
                end
                if (dout_v1 && out_rdy) begin
                    if (q1.size() == 0) chk("sb1_unexpected_beat", 1, 0);
                    else begin
                        e1 = q1.pop_front();
                        chk("sb1_data", int'($signed(dout1[0])), e1.data);
                        chk("sb1_last", int'(last1), int'(e1.last));
                    end
                end
                if (b_v && b_rdy0) n_bias_hs++;
                if (din_v && din_rdy0) begin
                    n_data_hs++;
                    q0.push_back('{model(int'($signed(din[0])), int'($signed(bin[0])), 3), col == 31});
                    q1.push_back('{model(int'($signed(din[0])), int'($signed(bin[0])), 5), col == 31});
                    col = (col + 1) % 32;
                end
            end
        end
    end

    function automatic logic [15:0] rnd16();
        int r;
        r = int'($urandom_range(0, 5));
        if (r == 0) return 16'h7fff;
        if (r == 1) return 16'h8000;
        return 16'($urandom);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (drv_rand) begin
            din[0] = rnd16();
            bin[0] = rnd16();
        end
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0;
        din_v = 1'b0;
        b_v = 1'b0;
        tick();
        q0.delete();
        q1.delete();
        col = 0;
        n_data_hs = 0; n_bias_hs = 0; n_out0 = 0; n_last0 = 0;
        rst = 1'b1;
    endtask

    task automatic drain(input string name);
        din_v = 1'b0;
        b_v = 1'b0;
        out_rdy = 1'b1;
        for (int c = 0; c < 30 && (q0.size() > 0 || q1.size() > 0); c++) tick();
        tick();
        chk(name, q0.size() + q1.size(), 0);
    endtask

    typedef struct { int d; int b; int e0; int e1; } vec_t;
    vec_t tv[10];

    initial begin
        din = '0; bin = '0; din_v = 1'b0; b_v = 1'b0; out_rdy = 1'b1;

        tv[0] = '{8, 16, 24, 12};
        tv[1] = '{8, 32, 40, 16};
        tv[2] = '{8, 1, 9, 8};
        tv[3] = '{32767, 1, 32767, 32767};
        tv[4] = '{-32768, -1, -32768, -32768};
        tv[5] = '{100, -50, 50, 87};
        tv[6] = '{32767, 32767, 32767, 32767};
        tv[7] = '{-32768, -32768, -32768, -32768};
        tv[8] = '{-5, 3, -2, -5};
        tv[9] = '{0, -4, -4, -1};

        // Reset state: readies mirror the other stream's valid
        repeat (2) @(posedge clk);
        #1 din_v = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", int'(dout_v0), 0);
        chk("rst_out_data", int'(dout0[0]), 0);
        chk("rst_out_last", int'(last0), 0);
        chk("rst_din_ready", int'(din_rdy0), 0);
        chk("rst_bias_ready", int'(b_rdy0), 1);
        tick();
        din_v = 1'b0;
        rst = 1'b1;

        // Directed single beats: fire, one-cycle gap, then result
        for (int i = 0; i < 10; i++) begin
            tick();
            din[0] = 16'(tv[i].d);
            bin[0] = 16'(tv[i].b);
            din_v = 1'b1;
            b_v = 1'b1;
            @(negedge clk);
            chk("tbl_fire", int'(din_rdy0 & b_rdy0), 1);
            tick();
            din_v = 1'b0;
            b_v = 1'b0;
            @(negedge clk);
            chk("tbl_latency_not_early", int'(dout_v0), 0);
            tick();
            @(negedge clk);
            chk("tbl_valid", int'(dout_v0), 1);
            chk("tbl_q3_data", int'($signed(dout0[0])), tv[i].e0);
            chk("tbl_q5bias_data", int'($signed(dout1[0])), tv[i].e1);
            chk("tbl_last", int'(last0), 0);
        end

        // Join/last: bias always offered, data on alternate cycles
        do_reset();
        sb_en = 1'b1;
        drv_rand = 1'b1;
        b_v = 1'b1;
        for (int c = 0; c < 128; c++) begin
            tick();
            din_v = (c % 2 == 0);
        end
        drain("join_drain");
        chk("join_bias_hs", n_bias_hs, 64);
        chk("join_data_hs", n_data_hs, 64);
        chk("join_out_beats", n_out0, 64);
        chk("join_last_count", n_last0, 2);

        // Backpressure: both stages fill and hold
        do_reset();
        din_v = 1'b1;
        b_v = 1'b1;
        out_rdy = 1'b1;
        repeat (6) tick();
        out_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_din_ready", int'(din_rdy0), 0);
            chk("stall_bias_ready", int'(b_rdy0), 0);
            chk("stall_valid", int'(dout_v0), 1);
            if (q0.size() > 0) begin
                chk("stall_hold_data", int'($signed(dout0[0])), q0[0].data);
                chk("stall_hold_last", int'(last0), int'(q0[0].last));
            end else chk("stall_queue_nonempty", 0, 1);
            tick();
        end
        out_rdy = 1'b1;
        repeat (10) tick();
        drain("stall_drain");
        chk("stall_no_drop_dup", n_out0, n_data_hs);

        // Random valids and ready
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tick();
            din_v = ($urandom_range(0, 3) != 0);
            b_v = ($urandom_range(0, 3) != 0);
            out_rdy = ($urandom_range(0, 2) != 0);
        end
        drain("rand_drain");
        chk("rand_join_balance", n_bias_hs, n_data_hs);
        chk("rand_out_count", n_out0, n_data_hs);

        // Reset mid-row after 10 beats
        do_reset();
        din_v = 1'b1;
        b_v = 1'b1;
        out_rdy = 1'b1;
        for (int c = 0; c < 40 && n_data_hs < 10; c++) @(negedge clk);
        chk("midrst_reached_10", n_data_hs, 10);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", int'(dout_v0), 0);
        chk("midrst_data", int'(dout0[0]), 0);
        chk("midrst_last", int'(last0), 0);
        tick();
        q0.delete();
        q1.delete();
        col = 0;
        n_data_hs = 0; n_bias_hs = 0; n_out0 = 0; n_last0 = 0;
        rst = 1'b1;
        for (int c = 0; c < 80 && n_data_hs < 32; c++) @(negedge clk);
        tick();
        din_v = 1'b0;
        b_v = 1'b0;
        drain("midrst_drain");
        chk("midrst_out_beats", n_out0, 32);
        chk("midrst_last_count", n_last0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/encoder_bias_add.md
# encoder_bias_add

Adds a streamed per-column bias vector to a streamed linear-layer result vector, lane by lane. The bias comes from a parameter source such as `encoder_layer_0_attention_self_query_bias_source`. The block joins the two valid/ready streams, aligns fixed-point formats and saturates to the output format. It emits results through a 2-stage elastic pipeline, with a row-end marker. It sits directly downstream of the query/key/value weight matmul and the matching bias source, and feeds the attention score stage.

## Interface
- `DATA_IN_0_PRECISION_0`, 16: data_in total bits (signed).
- `DATA_IN_0_PRECISION_1`, 3: data_in fractional bits.
- `BIAS_PRECISION_0`, 16: bias total bits (signed).
- `BIAS_PRECISION_1`, 3: bias fractional bits.
- `DATA_OUT_0_PRECISION_0`, 16: output total bits (signed).
- `DATA_OUT_0_PRECISION_1`, 3: output fractional bits.
- `TENSOR_SIZE_DIM_0`, 32: row length in elements.
- `PARALLELISM_DIM_0`, 1, and `PARALLELISM_DIM_1`, 1: lane grid. Lanes L = DIM_0 × DIM_1.
- `OUT_DEPTH`, TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0: beats per row.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: reset. Asynchronous, active-low; all state clears while `rst`=0.
- `data_in_0`  in  [DATA_IN_0_PRECISION_0-1:0] × L: matmul result lanes.
- `data_in_0_valid`  in  1; `data_in_0_ready`  out  1.
- `bias`  in  [BIAS_PRECISION_0-1:0] × L: bias lanes.
- `bias_valid`  in  1; `bias_ready`  out  1.
- `data_out_0`  out  [DATA_OUT_0_PRECISION_0-1:0] × L: biased, saturated lanes.
- `data_out_0_valid`  out  1; `data_out_0_ready`  in  1.
- `data_out_0_last`  out  1: high on the final beat of each row.

## Operation
- Join: fire = `data_in_0_valid` & `bias_valid` & stageA_accept.
  - `data_in_0_ready` = `bias_valid` & stageA_accept.
  - `bias_ready` = `data_in_0_valid` & stageA_accept.
  - A bias beat is never consumed without a data beat, and vice versa. This keeps the free-running bias source's column counter in phase.
- Bias alignment to data fractional bits: if `BIAS_PRECISION_1` < `DATA_IN_0_PRECISION_1`, shift left, sign-preserving. Otherwise arithmetic right shift, truncating toward −inf.
- Sum width = max(data int bits, bias int bits) + `DATA_IN_0_PRECISION_1` + 2 sign/carry bits. The sum never overflows internally.
- Stage A registers the per-lane sums, a valid bit and the last flag.
- Stage B rescales to `DATA_OUT_0_PRECISION_1`: left shift, or arithmetic right shift truncating. It then saturates to [−2^(P0−1), 2^(P0−1)−1] of the output width, and registers data, valid and last.
- Column counter (width clog2(OUT_DEPTH)+1):
  - Increments on each fire; wraps to 0 after OUT_DEPTH−1.
  - The last flag for a fired beat = (counter == OUT_DEPTH−1).
  - It travels with the data through both stages.

## Timing
- Latency: a fire in cycle N appears on `data_out_0` in cycle N+2 when unstalled. Throughput is 1 beat/cycle.
- Stage accept rules:
  - stageB_accept = !B_valid | `data_out_0_ready`.
  - stageA_accept = !A_valid | stageB_accept.
  - Bubbles collapse.
  - Ready paths are combinational from `data_out_0_ready`.
- Stall: while `data_out_0_valid`=1 & `data_out_0_ready`=0, `data_out_0` and `data_out_0_last` hold stable. With both stages full, both input readies are 0.
- Simultaneous drain and fill in the same cycle: the stage updates, and nothing is lost or duplicated.
- Reset values: `data_out_0_valid`=0, `data_out_0`=0, `data_out_0_last`=0, stage registers 0, counter 0. The input readies follow from the empty stages, so each equals the other stream's valid.
- Reset mid-row: in-flight beats are discarded and the counter returns to 0. The parent must reset the bias source in the same cycle so both restart at column 0.

## Structure
- Shared package `bias_add_pkg` holds:
  - Width localparam functions (sum width, counter width).
  - Fixed-point helpers: `fx_align` (signed shift by signed amount) and `fx_saturate` (clamp to N bits).
  - The lane-vector typedef pattern.
- One sub-module: `bias_add_pipe_reg`, a parameterised valid/ready register stage (payload width, accept logic). Instantiated twice, for stage A and stage B.
- Top level holds the join, the column counter and the combinational add/rescale.

## Test plan
- Basic add (all formats Q16.3, L=1): data 8 (1.0) + bias 16 (2.0) -> `data_out_0`=24, two cycles after fire.
- Saturation: 32767 + 1 -> 32767. −32768 + (−1) -> −32768. 100 + (−50) -> 50.
- Format mismatch (`BIAS_PRECISION_1`=5): data 8 (1.0) + bias 32 (1.0) -> 16. Bias 1 (2^−5) truncates to 0, so data 8 -> 8.
- Join/last: `bias_valid` held 1, `data_in_0_valid` pulsed on alternate cycles for 64 beats.
  - Exactly 64 bias handshakes.
  - `data_out_0_last` on output beats 32 and 64 only.
- Backpressure: `data_out_0_ready`=0 for 5 cycles mid-stream.
  - Both stages fill, both input readies go 0, output holds.
  - After release, the sequence is intact with no drop or duplicate.
- Reset mid-row: `rst`=0 after 10 beats.
  - Immediately `data_out_0_valid`=0.
  - After release, the first output beat has counter 0, and last asserts on beat 32.
